// File: rtl/tmplct_dly_pipe.sv
// Programmable TMB/LCT delay line: circular buffer of depth 2^DBITS with
// change-safe blanking so no pre-change or stale sample is ever presented.
//
// state | meaning
// ------+---------------------------------------------------------------
// INIT  | after reset; first edge loads DELAY unconditionally
// FILL  | buffer still holds pre-change samples; output blanked
// RUN   | buffer fully refilled; DOUT delayed by exactly DLY_CUR clocks
module tmplct_dly_pipe #(
  parameter int WIDTH = 1,
  parameter int DBITS = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DIN,
  input  logic [DBITS-1:0] DELAY,
  output logic [WIDTH-1:0] DOUT,
  output logic             VALID,
  output logic [DBITS-1:0] DLY_CUR,
  output logic             DLY_CHG
);

  localparam int DEPTH = 1 << DBITS;

  typedef enum logic [1:0] {INIT, FILL, RUN} state_t;

  state_t           state;
  logic [DBITS-1:0] wp;
  logic [DBITS-1:0] fcnt;
  logic [DBITS-1:0] rd_addr;
  logic             reload;
  logic [WIDTH-1:0] mem [DEPTH];

  // INIT reloads even when DELAY already matches the reset value of DLY_CUR
  assign reload = (state == INIT) || (DELAY != DLY_CUR);

  // Storage is deliberately not reset; blanking hides anything stale.
  always_ff @(posedge CLK) begin
    mem[wp] <= DIN;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= INIT;
      wp      <= '0;
      fcnt    <= '0;
      DLY_CUR <= '0;
      DLY_CHG <= 1'b0;
    end else begin
      wp <= wp + DBITS'(1);
      if (reload) begin
        DLY_CUR <= DELAY;
        fcnt    <= DELAY;
        DLY_CHG <= 1'b1;
        state   <= (DELAY != '0) ? FILL : RUN;
      end else begin
        DLY_CHG <= 1'b0;
        if (state == FILL) begin
          if (fcnt == DBITS'(1)) begin
            state <= RUN;
            fcnt  <= '0;
          end else begin
            fcnt <= fcnt - DBITS'(1);
          end
        end
      end
    end
  end

  // Read never lands on wp unless DLY_CUR is 0, which takes the bypass.
  assign rd_addr = wp - DLY_CUR;
  assign VALID   = (state == RUN);
  assign DOUT    = VALID ? ((DLY_CUR == '0) ? DIN : mem[rd_addr]) : '0;

endmodule
